// File: rtl/uart_msg_arbiter_if.sv
// Handshake and serializer bundle for uart_msg_arbiter.
// Requester side is master; the arbiter is slave.
interface uart_msg_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic [63:0]      req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [63:0]      req1_data;
  logic             req1_ready;
  logic [63:0]      tx_data;
  logic [1:0]       uart_start;
  logic             busy;
  logic             grant_id;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  tx_data, uart_start, busy,
    input  grant_id, cnt0, cnt1
  );

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    output req0_ready, req1_ready,
    output tx_data, uart_start, busy,
    output grant_id, cnt0, cnt1
  );
endinterface

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing one UART message serializer
// between CAN-frame (port 0) and status (port 1) sources.
module uart_msg_arbiter #(
  parameter int MSG_CYCLES = 108500,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_msg_arbiter_if.slave bus
);
  localparam int W = $clog2(MSG_CYCLES);
  localparam logic [W-1:0] LOAD = W'(MSG_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_cnt;
  logic [63:0]      r_tx;
  logic             r_start;
  logic             r_busy;
  logic             r_gid;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc;

  // Ties go to the port that did not win last time.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == IDLE && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || r_last))
        w_gnt0 = 1'b1;
      else if (bus.req1_valid)
        w_gnt1 = 1'b1;
    end
  end

  assign w_acc = w_gnt0 | w_gnt1;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_gid   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_state <= w_next;
      r_start <= w_acc;
      r_busy  <= (w_next != IDLE);
      if (w_acc) begin
        r_tx   <= w_gnt1 ? bus.req1_data : bus.req0_data;
        r_gid  <= w_gnt1;
        r_last <= w_gnt1;
        r_cnt  <= LOAD;
        if (w_gnt0 && r_cnt0 != '1)
          r_cnt0 <= r_cnt0 + 1'b1;
        if (w_gnt1 && r_cnt1 != '1)
          r_cnt1 <= r_cnt1 + 1'b1;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.tx_data    = r_tx;
  assign bus.uart_start = {1'b0, r_start};
  assign bus.busy       = r_busy;
  assign bus.grant_id   = r_gid;
  assign bus.cnt0       = r_cnt0;
  assign bus.cnt1       = r_cnt1;
endmodule
